grey_seq: RTL and testbench

Sequencer/controller for the 12-digit grey-coded decimal counter. It serially loads the 60-bit init word and issues the counter load pulse. It gates counting through a prescaled count-enable, snapshots the counter's 12 digits and streams them out as BCD over a valid/ready handshake.

---
 rtl/grey_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_grey_seq.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grey_seq.sv
// grey_seq: sequencer/controller for the 12-digit grey-coded decimal counter.
//
// Serially loads the counter init word (MSD first), issues a one-cycle load
// strobe, gates counting with a prescaled count-enable while running, and
// snapshots the live counter digits to stream them out as BCD over a
// valid/ready handshake.
//
// Build option: define GREY_SEQ_ZSUPP_EN to suppress leading zero digits in
// the output stream (the ones digit is always emitted).
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_cmd/i_cmd_valid        command 0=STOP 1=RUN 2=LOAD 3=SNAP
//   o_cmd_ready              high in IDLE/RUN only
//   i_din/i_din_valid        init digit (grey code), MSD first
//   o_din_ready              high in LOAD only
//   o_init                   init word, digit 0 (ones) in [4:0]
//   o_ctr_load               one-cycle counter load strobe
//   o_ctr_en                 one-cycle counter advance strobe
//   i_digits                 live counter digits, same packing as o_init
//   o_dout/o_dout_last       BCD output digit, last marks the ones digit
//   o_dout_valid/i_dout_ready  output handshake
//   o_busy                   state is LOAD, APPLY or SCAN
//   o_err                    sticky invalid-code flag
module grey_seq #(
    parameter int NDIG     = 12,
    parameter int PRESCALE = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [1:0]          i_cmd,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [4:0]          i_din,
    input  logic                i_din_valid,
    output logic                o_din_ready,
    output logic [5*NDIG-1:0]   o_init,
    output logic                o_ctr_load,
    output logic                o_ctr_en,
    input  logic [5*NDIG-1:0]   i_digits,
    output logic [3:0]          o_dout,
    output logic                o_dout_last,
    output logic                o_dout_valid,
    input  logic                i_dout_ready,
    output logic                o_busy,
    output logic                o_err
);

    localparam int W     = 5 * NDIG;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PS_W  = $clog2(PRESCALE);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NDIG - 1);
    localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [4:0]       ZERO_CODE = 5'b10001;

    localparam logic [1:0] CMD_STOP = 2'd0;
    localparam logic [1:0] CMD_RUN  = 2'd1;
    localparam logic [1:0] CMD_LOAD = 2'd2;
    localparam logic [1:0] CMD_SNAP = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_LOAD,
        ST_APPLY,
        ST_SCAN
    } state_t;

    // Grey digit code to BCD; any code outside the table maps to 4'hF.
    function automatic logic [3:0] grey_to_bcd(input logic [4:0] code);
        case (code)
            5'b10001: return 4'd0;
            5'b00001: return 4'd1;
            5'b00011: return 4'd2;
            5'b00010: return 4'd3;
            5'b00110: return 4'd4;
            5'b00100: return 4'd5;
            5'b01100: return 4'd6;
            5'b01000: return 4'd7;
            5'b11000: return 4'd8;
            5'b10000: return 4'd9;
            default:  return 4'hF;
        endcase
    endfunction

    function automatic logic code_valid(input logic [4:0] code);
        return grey_to_bcd(code) != 4'hF;
    endfunction

`ifdef GREY_SEQ_ZSUPP_EN
    // Index of the most significant digit that is not a zero code; 0 when
    // every digit is zero so the ones digit is still emitted.
    function automatic logic [IDX_W-1:0] first_nz(input logic [NDIG-1:0][4:0] w);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (w[i] != ZERO_CODE) r = IDX_W'(i);
        end
        return r;
    endfunction
`endif

    state_t                  state;
    state_t                  state_nxt;
    logic [PS_W-1:0]         presc;
    logic                    run_saved;
    logic [IDX_W-1:0]        dig_idx;
    logic [IDX_W-1:0]        scan_idx;
    logic [NDIG-1:0][4:0]    snap;

    logic                    cmd_fire;
    logic                    din_fire;
    logic                    dout_fire;
    logic                    load_done;
    logic                    scan_done;
    logic                    count_act;
    logic                    presc_wrap;
    logic                    din_ok;
    logic [4:0]              cur_code;
    logic                    cur_ok;
    logic [IDX_W-1:0]        start_idx;

    assign cmd_fire   = i_cmd_valid && o_cmd_ready;
    assign din_fire   = i_din_valid && o_din_ready;
    assign dout_fire  = o_dout_valid && i_dout_ready;
    assign load_done  = din_fire && (dig_idx == LAST_IDX);
    assign scan_done  = dout_fire && (scan_idx == '0);
    assign presc_wrap = (presc == PS_LAST);
    assign din_ok     = code_valid(i_din);
    assign cur_code   = snap[scan_idx];
    assign cur_ok     = code_valid(cur_code);

    // Counting runs in RUN and through a scan started from RUN. A STOP or
    // LOAD accepted in RUN kills the enable already in its accept cycle so
    // no strobe leaks out afterwards.
    assign count_act = ((state == ST_RUN) &&
                        !(cmd_fire && ((i_cmd == CMD_STOP) || (i_cmd == CMD_LOAD)))) ||
                       ((state == ST_SCAN) && run_saved);

`ifdef GREY_SEQ_ZSUPP_EN
    assign start_idx = first_nz(i_digits);
`else
    assign start_idx = LAST_IDX;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (i_cmd)
                        CMD_RUN:  state_nxt = ST_RUN;
                        CMD_LOAD: state_nxt = ST_LOAD;
                        CMD_SNAP: state_nxt = ST_SCAN;
                        default:  state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                if (cmd_fire) begin
                    case (i_cmd)
                        CMD_STOP: state_nxt = ST_IDLE;
                        CMD_LOAD: state_nxt = ST_LOAD;
                        CMD_SNAP: state_nxt = ST_SCAN;
                        default:  state_nxt = ST_RUN;
                    endcase
                end
            end
            ST_LOAD:  if (load_done) state_nxt = ST_APPLY;
            ST_APPLY: state_nxt = ST_IDLE;
            ST_SCAN:  if (scan_done) state_nxt = run_saved ? ST_RUN : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_cmd_ready  = (state == ST_IDLE) || (state == ST_RUN);
        o_din_ready  = (state == ST_LOAD);
        o_ctr_load   = (state == ST_APPLY);
        o_busy       = (state == ST_LOAD) || (state == ST_APPLY) || (state == ST_SCAN);
        o_dout_valid = (state == ST_SCAN);
        o_dout       = (state == ST_SCAN) ? grey_to_bcd(cur_code) : 4'd0;
        o_dout_last  = (state == ST_SCAN) && (scan_idx == '0);
    end

    // Control and init-word registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc     <= '0;
            o_ctr_en  <= 1'b0;
            run_saved <= 1'b0;
            o_init    <= {NDIG{ZERO_CODE}};
            o_err     <= 1'b0;
            dig_idx   <= '0;
            scan_idx  <= '0;
        end else begin
            o_ctr_en <= count_act && presc_wrap;

            if (count_act)
                presc <= presc_wrap ? '0 : presc + 1'b1;
            else if (cmd_fire && (state == ST_IDLE) && (i_cmd == CMD_RUN))
                presc <= '0;

            if (cmd_fire && (i_cmd == CMD_LOAD)) begin
                o_err   <= 1'b0;
                dig_idx <= '0;
            end

            if (cmd_fire && (i_cmd == CMD_SNAP)) begin
                run_saved <= (state == ST_RUN);
                scan_idx  <= start_idx;
            end

            // New digits enter at the ones position; after NDIG beats the
            // first digit received sits in the most significant slot.
            if (din_fire) begin
                o_init  <= {o_init[W-6:0], din_ok ? i_din : ZERO_CODE};
                dig_idx <= dig_idx + 1'b1;
                if (!din_ok) o_err <= 1'b1;
            end

            if (dout_fire) begin
                if (!cur_ok) o_err <= 1'b1;
                if (scan_idx != '0) scan_idx <= scan_idx - 1'b1;
            end
        end
    end

    // Snapshot holds data only; its contents are meaningless outside SCAN
    always_ff @(posedge i_clk) begin
        if (cmd_fire && (i_cmd == CMD_SNAP)) snap <= i_digits;
    end

endmodule

// File: tb/tb_grey_seq.sv
module tb_grey_seq;

    localparam int NDIG     = 12;
    localparam int PRESCALE = 4;
    localparam int W        = 5 * NDIG;

    localparam logic [1:0] C_STOP = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_LOAD = 2'd2;
    localparam logic [1:0] C_SNAP = 2'd3;

    localparam logic [4:0] GREY [10] = '{5'b10001, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
                                        5'b00100, 5'b01100, 5'b01000, 5'b11000, 5'b10000};

    logic           i_clk;
    logic           i_rst_n;
    logic [1:0]     i_cmd;
    logic           i_cmd_valid;
    logic           o_cmd_ready;
    logic [4:0]     i_din;
    logic           i_din_valid;
    logic           o_din_ready;
    logic [W-1:0]   o_init;
    logic           o_ctr_load;
    logic           o_ctr_en;
    logic [W-1:0]   i_digits;
    logic [3:0]     o_dout;
    logic           o_dout_last;
    logic           o_dout_valid;
    logic           i_dout_ready;
    logic           o_busy;
    logic           o_err;

    grey_seq #(.NDIG(NDIG), .PRESCALE(PRESCALE)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_cmd        (i_cmd),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_din        (i_din),
        .i_din_valid  (i_din_valid),
        .o_din_ready  (o_din_ready),
        .o_init       (o_init),
        .o_ctr_load   (o_ctr_load),
        .o_ctr_en     (o_ctr_en),
        .i_digits     (i_digits),
        .o_dout       (o_dout),
        .o_dout_last  (o_dout_last),
        .o_dout_valid (o_dout_valid),
        .i_dout_ready (i_dout_ready),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit           run_on  = 0;   // counter expected to be advancing
    int           run_cyc = 0;   // cycles since RUN accept
    logic [W-1:0] exp_init;
    bit           exp_err = 0;
    int           exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int code2dig(input logic [4:0] c);
        for (int i = 0; i < 10; i++) if (GREY[i] == c) return i;
        return 15;
    endfunction

    function automatic logic [4:0] bad_code();
        logic [4:0] c;
        do c = 5'($urandom); while (code2dig(c) != 15);
        return c;
    endfunction

    function automatic logic [W-1:0] pack(input logic [4:0] c [NDIG]);
        logic [W-1:0] r;
        for (int i = 0; i < NDIG; i++) r[5*i +: 5] = c[i];
        return r;
    endfunction

    function automatic logic [W-1:0] all_zero();
        logic [4:0] c [NDIG];
        for (int i = 0; i < NDIG; i++) c[i] = GREY[0];
        return pack(c);
    endfunction

    // One clock; the count-enable is checked against a pulse every
    // PRESCALE cycles counted from the RUN accept.
    task automatic tick();
        @(posedge i_clk);
        #1;
        if (run_on) begin
            run_cyc++;
            check("ctr_en_run", o_ctr_en, ((run_cyc % PRESCALE) == 0) ? 1 : 0);
        end else begin
            check("ctr_en_off", o_ctr_en, 0);
        end
    endtask

    task automatic send_cmd(input logic [1:0] c);
        int  g;
        bit  was_on;
        g = 0;
        i_cmd = c;
        i_cmd_valid = 1'b1;
        while (!o_cmd_ready && g < 200) begin
            tick();
            g++;
        end
        if (!o_cmd_ready) begin
            check("cmd_timeout", 0, 1);
            i_cmd_valid = 1'b0;
            return;
        end
        was_on = run_on;
        if (c == C_STOP || c == C_LOAD) run_on = 0;
        if (c == C_LOAD) exp_err = 0;
        tick();
        if (c == C_RUN && !was_on) begin
            run_on  = 1;
            run_cyc = 0;
        end
        i_cmd_valid = 1'b0;
    endtask

    // dg[0] is the first (most significant) digit sent.
    task automatic load_word(input int dg [NDIG], input bit bad [NDIG]);
        logic [4:0] slot [NDIG];
        for (int k = 0; k < NDIG; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                i_din_valid = 1'b0;
                i_din = 5'($urandom);
                tick();
            end
            i_din = bad[k] ? bad_code() : GREY[dg[k]];
            i_din_valid = 1'b1;
            check("din_ready", o_din_ready, 1);
            tick();
            slot[NDIG-1-k] = bad[k] ? GREY[0] : GREY[dg[k]];
            if (bad[k]) exp_err = 1;
        end
        i_din_valid = 1'b0;
        exp_init = pack(slot);
        check("apply_load", o_ctr_load, 1);
        check("apply_din_rdy", o_din_ready, 0);
        check("apply_busy", o_busy, 1);
        tick();
        check("load_pulse_end", o_ctr_load, 0);
        check("load_idle_rdy", o_cmd_ready, 1);
        check("init_word", o_init, exp_init);
        check("load_err", o_err, exp_err);
    endtask

    task automatic rand_load(input int bad_pct);
        int dg [NDIG];
        bit bad [NDIG];
        for (int k = 0; k < NDIG; k++) begin
            dg[k]  = $urandom_range(0, 9);
            bad[k] = ($urandom_range(0, 99) < bad_pct);
        end
        send_cmd(C_LOAD);
        check("load_err_clr", o_err, 0);
        load_word(dg, bad);
    endtask

    // codes[i] is digit i (0 = ones).
    task automatic do_snap(input logic [4:0] codes [NDIG], input int hold_low, input bit pend);
        int start, idx, g, hl;
        bit rdy;
        i_digits = pack(codes);
        send_cmd(C_SNAP);
        i_digits = {2{$urandom}};
        start = NDIG - 1;
`ifdef GREY_SEQ_ZSUPP_EN
        start = 0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (codes[i] != GREY[0]) begin
                start = i;
                break;
            end
        end
`endif
        exp_q.delete();
        for (int i = start; i >= 0; i--) begin
            exp_q.push_back(code2dig(codes[i]));
            if (code2dig(codes[i]) == 15) exp_err = 1;
        end
        if (pend) begin
            i_cmd = C_LOAD;
            i_cmd_valid = 1'b1;
        end
        idx = 0;
        g = 0;
        hl = hold_low;
        while (idx < exp_q.size() && g < 500) begin
            if (hl > 0) begin
                rdy = 0;
                hl--;
            end else begin
                rdy = $urandom_range(0, 1);
            end
            i_dout_ready = rdy;
            check("dout_valid", o_dout_valid, 1);
            check("dout_busy", o_busy, 1);
            check("dout_val", o_dout, exp_q[idx]);
            check("dout_last", o_dout_last, (idx == exp_q.size() - 1) ? 1 : 0);
            if (pend) check("cmd_stall", o_cmd_ready, 0);
            tick();
            if (rdy) idx++;
            g++;
        end
        if (idx < exp_q.size()) check("scan_timeout", 0, 1);
        i_dout_ready = 1'b0;
        check("scan_end_valid", o_dout_valid, 0);
        check("scan_end_busy", o_busy, 0);
        check("scan_end_rdy", o_cmd_ready, 1);
        check("scan_err", o_err, exp_err);
    endtask

    task automatic rand_codes(output logic [4:0] codes [NDIG]);
        int nlz;
        nlz = $urandom_range(0, NDIG);
        for (int i = 0; i < NDIG; i++) begin
            if (i >= NDIG - nlz)                codes[i] = GREY[0];
            else if ($urandom_range(0, 9) == 0) codes[i] = bad_code();
            else                                codes[i] = GREY[$urandom_range(0, 9)];
        end
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        #1;
        run_on   = 0;
        exp_err  = 0;
        exp_init = all_zero();
        check("rst_valid", o_dout_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_init", o_init, exp_init);
        check("rst_cmd_rdy", o_cmd_ready, 1);
        check("rst_err", o_err, 0);
        i_cmd_valid  = 1'b0;
        i_din_valid  = 1'b0;
        i_dout_ready = 1'b0;
        @(posedge i_clk);
        #1;
        check("rst_din_rdy", o_din_ready, 0);
        i_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         dg [NDIG];
        bit         bad [NDIG];
        logic [4:0] codes [NDIG];
        int         runs [3];

        i_rst_n = 1'b0;
        i_cmd = C_STOP;
        i_cmd_valid = 1'b0;
        i_din = 5'd0;
        i_din_valid = 1'b0;
        i_digits = '0;
        i_dout_ready = 1'b0;
        exp_init = all_zero();
        repeat (2) @(posedge i_clk);
        #1;

        check("reset_cmd_rdy", o_cmd_ready, 1);
        check("reset_din_rdy", o_din_ready, 0);
        check("reset_init", o_init, exp_init);
        check("reset_load", o_ctr_load, 0);
        check("reset_en", o_ctr_en, 0);
        check("reset_valid", o_dout_valid, 0);
        check("reset_dout", o_dout, 0);
        check("reset_last", o_dout_last, 0);
        check("reset_busy", o_busy, 0);
        check("reset_err", o_err, 0);
        i_rst_n = 1'b1;
        tick();

        // din outside LOAD is ignored
        i_din = 5'b00011;
        i_din_valid = 1'b1;
        repeat (3) tick();
        i_din_valid = 1'b0;
        check("din_ignored", o_init, exp_init);

        // Directed load 1,2,...,9,0,1,2 MSD first
        dg = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        for (int k = 0; k < NDIG; k++) bad[k] = 0;
        send_cmd(C_LOAD);
        load_word(dg, bad);
        check("init_ones", o_init[4:0], 5'b00011);
        check("init_msd", o_init[59:55], 5'b00001);

        // Third digit invalid, then a new LOAD clears the flag
        for (int k = 0; k < NDIG; k++) dg[k] = $urandom_range(0, 9);
        bad[2] = 1;
        send_cmd(C_LOAD);
        load_word(dg, bad);
        check("bad_slot", o_init[5*(NDIG-3) +: 5], GREY[0]);
        check("bad_err", o_err, 1);
        rand_load(0);

        // RUN / STOP timing, including a STOP landing on a pulse cycle
        runs = '{20, 23, 0};
        runs[2] = $urandom_range(5, 17);
        for (int r = 0; r < 3; r++) begin
            send_cmd(C_RUN);
            repeat (runs[r]) tick();
            send_cmd(C_STOP);
            repeat (8) tick();
        end

        // Snapshot 000000000907 in IDLE with output stalled 3 cycles
        for (int i = 0; i < NDIG; i++) codes[i] = GREY[0];
        codes[2] = GREY[9];
        codes[0] = GREY[7];
        do_snap(codes, 3, 0);
        repeat (3) tick();

        // Snapshot during RUN: counting continues, returns to RUN
        send_cmd(C_RUN);
        repeat ($urandom_range(1, 6)) tick();
        rand_codes(codes);
        do_snap(codes, 0, 0);
        repeat (9) tick();
        send_cmd(C_STOP);

        // Snapshot during RUN with a LOAD pending through the scan
        send_cmd(C_RUN);
        repeat ($urandom_range(1, 6)) tick();
        rand_codes(codes);
        do_snap(codes, 1, 1);
        send_cmd(C_LOAD);
        check("pend_load_err", o_err, 0);
        for (int k = 0; k < NDIG; k++) begin
            dg[k]  = $urandom_range(0, 9);
            bad[k] = 0;
        end
        load_word(dg, bad);

        // Randomized mix of loads and snapshots
        for (int it = 0; it < 8; it++) begin
            bit in_run, pend;
            rand_load(12);
            in_run = $urandom_range(0, 1);
            pend   = $urandom_range(0, 1);
            if (in_run) begin
                send_cmd(C_RUN);
                repeat ($urandom_range(0, 7)) tick();
            end
            rand_codes(codes);
            do_snap(codes, $urandom_range(0, 2), pend);
            if (pend) begin
                send_cmd(C_LOAD);
                for (int k = 0; k < NDIG; k++) begin
                    dg[k]  = $urandom_range(0, 9);
                    bad[k] = 0;
                end
                load_word(dg, bad);
            end else if (in_run) begin
                repeat ($urandom_range(1, 9)) tick();
                send_cmd(C_STOP);
            end
        end

        // Reset in the middle of SCAN
        rand_load(0);
        send_cmd(C_RUN);
        repeat (2) tick();
        rand_codes(codes);
        i_digits = pack(codes);
        send_cmd(C_SNAP);
        i_dout_ready = 1'b0;
        tick();
        check("pre_rst_valid", o_dout_valid, 1);
        do_reset();

        // Reset in the middle of LOAD
        send_cmd(C_LOAD);
        for (int k = 0; k < 5; k++) begin
            i_din = GREY[$urandom_range(1, 9)];
            i_din_valid = 1'b1;
            tick();
        end
        i_din_valid = 1'b0;
        check("mid_load_busy", o_busy, 1);
        do_reset();
        repeat (3) tick();
        check("post_rst_init", o_init, exp_init);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
